addr_issue_queue: RTL and testbench
===================================

ADDR_ISSUE_QUEUE -- requirements
Module: addr_issue_queue

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries; SHALL be a power of two >= 2.
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter DATA_W, 32, response data width.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 io_in_valid  input  1  arbitrated address request present.
REQ-007 io_in_ready  output  1  queue can accept a request.
REQ-008 io_in_bits_address  input  ADDR_W  request address.
REQ-009 io_mem_req_valid  output  1  memory request issued.
REQ-010 io_mem_req_ready  input  1  memory accepts request.
REQ-011 io_mem_req_bits_address  output  ADDR_W  address sent to memory.
REQ-012 io_mem_resp_valid  input  1  memory response present, single-cycle pulse, no backpressure.
REQ-013 io_mem_resp_bits_data  input  DATA_W  response data.
REQ-014 io_out_valid  output  1  completed transaction available.
REQ-015 io_out_ready  input  1  consumer accepts result.
REQ-016 io_out_bits_address  output  ADDR_W  address of completed transaction.
REQ-017 io_out_bits_data  output  DATA_W  data of completed transaction.
REQ-018 io_count  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 FIFO: circular buffer, read/write pointers wrap modulo DEPTH; io_in_ready SHALL equal (count != DEPTH); no bypass, an enqueued entry SHALL be visible to the FSM no earlier than the next cycle.
REQ-020 Enqueue SHALL occur when io_in_valid & io_in_ready; dequeue only on FSM load (REQ-022); simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-021 FSM states: IDLE, REQ, WAIT, RESP; exactly one issued transaction outstanding at any time.
REQ-022 Load: from IDLE with count != 0, or from RESP on io_out_ready with count != 0, the head entry SHALL be dequeued into the address register and the state SHALL become REQ; RESP on io_out_ready with count == 0 SHALL go to IDLE.
REQ-023 REQ: io_mem_req_valid = 1, io_mem_req_bits_address = address register, held stable until io_mem_req_ready; on io_mem_req_ready -> WAIT.
REQ-024 WAIT: on io_mem_resp_valid, data SHALL be captured into the data register and state -> RESP; io_mem_resp_valid in any other state SHALL be ignored.
REQ-025 RESP: io_out_valid = 1 with io_out_bits_address/io_out_bits_data from registers, held stable until io_out_ready.
REQ-026 io_mem_req_valid SHALL be 1 only in REQ; io_out_valid SHALL be 1 only in RESP; both are registered-state decodes with no combinational path from any input.
REQ-027 Latency: request enqueued at edge E into an empty queue with FSM in IDLE SHALL have io_mem_req_valid high in the cycle following edge E+1 (2 cycles); response in WAIT at edge R SHALL give io_out_valid in the cycle after R.
REQ-028 Back-to-back: with queue non-empty, io_out_ready in RESP SHALL produce io_mem_req_valid the very next cycle (no IDLE bubble).
REQ-029 Ordering: results SHALL leave in exact enqueue order; no entry SHALL be dropped or duplicated.
REQ-030 io_in_ready SHALL depend only on count, never on io_in_valid.

Reset
REQ-031 While reset = 0: count, pointers = 0; state = IDLE; address/data registers = 0; io_in_ready = 1; io_mem_req_valid = 0; io_out_valid = 0; io_count = 0; outputs SHALL take these values immediately on assertion, not waiting for a clock edge.
REQ-032 Reset asserted mid-transaction SHALL discard queued entries and any outstanding request; a response arriving after deassertion SHALL be ignored (state IDLE).
REQ-033 FIFO storage array need not be reset.

Verification
REQ-034 Single: enqueue 0x1000, mem_req_ready=1, resp 0xDEADBEEF one cycle later, out_ready=1 -> mem_req_valid 2 cycles after enqueue edge; out = {0x1000, 0xDEADBEEF}; io_count 1 then 0.
REQ-035 Fill: 5 enqueues with mem_req_ready=0 -> first loaded, next 4 fill FIFO, io_count=4, io_in_ready=0; 6th request stalls until first completion.
REQ-036 Stream: addresses 0x0..0x1C step 4, random req_ready/out_ready stalls, resp data = ~address -> 8 outputs in order, data matches, no RESP->REQ bubble when queue non-empty.
REQ-037 Spurious: resp_valid pulsed in IDLE and REQ -> no state change, no output.
REQ-038 Reset in WAIT with 3 entries queued -> all outputs to reset values asynchronously; resp after release ignored; io_count=0.
REQ-039 Wrap: 12 sequential transactions with concurrent enqueue/dequeue at count=DEPTH-1 -> pointers wrap, order preserved, count never exceeds 4.

Source files
------------

// File: rtl/addr_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : addr_issue_queue                                             |
// | Description : Address FIFO feeding a single-outstanding memory issue FSM.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module addr_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [ADDR_W-1:0]       io_in_bits_address,
  output logic                    io_mem_req_valid,
  input  logic                    io_mem_req_ready,
  output logic [ADDR_W-1:0]       io_mem_req_bits_address,
  input  logic                    io_mem_resp_valid,
  input  logic [DATA_W-1:0]       io_mem_resp_bits_data,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [ADDR_W-1:0]       io_out_bits_address,
  output logic [DATA_W-1:0]       io_out_bits_data,
  output logic [$clog2(DEPTH):0]  io_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  state_t            r_state;
  logic              r_req_valid;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic w_enq;
  logic w_load;
  logic w_not_empty;

  assign w_not_empty = (r_count != '0);
  assign io_in_ready = (r_count != C_FULL);
  assign w_enq       = io_in_valid & io_in_ready;
  // Head is popped only when the FSM is free to take it, never bypassed.
  assign w_load      = w_not_empty &
                       ((r_state == S_IDLE) | ((r_state == S_RESP) & io_out_ready));

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= io_in_bits_address;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_addr      <= r_mem[r_rd_ptr];
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          if (io_mem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (io_mem_resp_valid) begin
            r_data      <= io_mem_resp_bits_data;
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (io_out_ready) begin
            r_out_valid <= 1'b0;
            // Chain straight into the next request to avoid an IDLE bubble.
            if (w_not_empty) begin
              r_addr      <= r_mem[r_rd_ptr];
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_mem_req_valid        = r_req_valid;
  assign io_mem_req_bits_address = r_addr;
  assign io_out_valid            = r_out_valid;
  assign io_out_bits_address     = r_addr;
  assign io_out_bits_data        = r_data;
  assign io_count                = r_count;

  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    r_count <= C_FULL);
  a_valid_exclusive: assert property (@(posedge clock) disable iff (!reset)
    !(r_req_valid && r_out_valid));
  a_req_hold: assert property (@(posedge clock) disable iff (!reset)
    (r_req_valid && !io_mem_req_ready) |=> (r_req_valid && $stable(r_addr)));
  a_out_hold: assert property (@(posedge clock) disable iff (!reset)
    (r_out_valid && !io_out_ready) |=> (r_out_valid && $stable(r_data)));

endmodule
`default_nettype wire

// File: tb/tb_addr_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_addr_issue_queue                                          |
// | Description : Directed vector table plus multi-cycle sequences.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_addr_issue_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_bits_address;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready;
  logic [31:0] io_mem_req_bits_address;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_bits_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_bits_address;
  logic [31:0] io_out_bits_data;
  logic [2:0]  io_count;

  addr_issue_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_in_valid             (io_in_valid),
    .io_in_ready             (io_in_ready),
    .io_in_bits_address      (io_in_bits_address),
    .io_mem_req_valid        (io_mem_req_valid),
    .io_mem_req_ready        (io_mem_req_ready),
    .io_mem_req_bits_address (io_mem_req_bits_address),
    .io_mem_resp_valid       (io_mem_resp_valid),
    .io_mem_resp_bits_data   (io_mem_resp_bits_data),
    .io_out_valid            (io_out_valid),
    .io_out_ready            (io_out_ready),
    .io_out_bits_address     (io_out_bits_address),
    .io_out_bits_data        (io_out_bits_data),
    .io_count                (io_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_ready;
    logic        e_in_ready;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_out_valid;
    logic [31:0] e_out_addr;
    logic [31:0] e_out_data;
    logic [2:0]  e_count;
  } vec_t;

  vec_t        vecs [14];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] send_q [$];
  logic [31:0] exp_q  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    io_in_valid           = 1'b0;
    io_in_bits_address    = '0;
    io_mem_req_ready      = 1'b0;
    io_mem_resp_valid     = 1'b0;
    io_mem_resp_bits_data = '0;
    io_out_ready          = 1'b0;
  endtask

  // Drives requests from send_q, answers each memory request one cycle after its
  // handshake with data = ~address, and checks results against exp_q in order.
  task automatic run_stream(input bit stall, input int budget);
    bit          pending    = 1'b0;
    bit          expect_req = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          cyc        = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      io_in_valid           = (send_q.size() != 0);
      io_in_bits_address    = (send_q.size() != 0) ? send_q[0] : 32'h0;
      io_mem_req_ready      = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      io_out_ready          = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      io_mem_resp_valid     = pending;
      io_mem_resp_bits_data = ~pend_addr;
      #1;
      if (expect_req) chk("no_bubble_req_valid", {63'd0, io_mem_req_valid}, 64'd1);
      expect_req = 1'b0;
      chk("count_bound", {63'd0, (io_count <= 3'(DEPTH))}, 64'd1);
      pending = 1'b0;
      if (io_mem_req_valid && io_mem_req_ready) begin
        pending   = 1'b1;
        pend_addr = io_mem_req_bits_address;
      end
      if (io_out_valid && io_out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output actual=%0h expected=none", io_out_bits_address);
        end else begin
          chk("out_addr", {32'd0, io_out_bits_address}, {32'd0, exp_q[0]});
          chk("out_data", {32'd0, io_out_bits_data}, {32'd0, ~exp_q[0]});
          if (exp_q.size() >= 2) expect_req = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      if (io_in_valid && io_in_ready) exp_q.push_back(send_q.pop_front());
      step();
      cyc++;
    end
    idle_inputs();
    chk("stream_complete_remaining", 64'(send_q.size() + exp_q.size()), 64'd0);
    send_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // in_v addr rr rv rdata or | in_rdy req_v req_addr out_v out_addr out_data cnt
    vecs[0]  = '{1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd0};
    vecs[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd1};
    vecs[2]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0,    32'h0,        3'd0};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd0};
    vecs[4]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h1000, 32'hDEADBEEF, 3'd0};
    vecs[5]  = '{1'b1, 32'h2000, 1'b0, 1'b1, 32'h1111,     1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd0};
    vecs[6]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h1111,     1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd1};
    vecs[7]  = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h1111,     1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h0,    32'h0,        3'd0};
    vecs[8]  = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h0,    32'h0,        3'd0};
    vecs[9]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd0};
    vecs[10] = '{1'b0, 32'h0,    1'b0, 1'b1, 32'h2222,     1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd0};
    vecs[11] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 32'h2000, 32'h2222,     3'd0};
    vecs[12] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,    1'b1, 32'h2000, 32'h2222,     3'd0};
    vecs[13] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        3'd0};

    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_in_ready",  {63'd0, io_in_ready},      64'd1);
    chk("rst_req_valid", {63'd0, io_mem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, io_out_valid},     64'd0);
    chk("rst_count",     {61'd0, io_count},         64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Single transaction and spurious-response vectors.
    for (int i = 0; i < 14; i++) begin
      io_in_valid           = vecs[i].in_valid;
      io_in_bits_address    = vecs[i].in_addr;
      io_mem_req_ready      = vecs[i].req_ready;
      io_mem_resp_valid     = vecs[i].resp_valid;
      io_mem_resp_bits_data = vecs[i].resp_data;
      io_out_ready          = vecs[i].out_ready;
      #1;
      chk($sformatf("v%0d_in_ready", i),  {63'd0, io_in_ready},      {63'd0, vecs[i].e_in_ready});
      chk($sformatf("v%0d_req_valid", i), {63'd0, io_mem_req_valid}, {63'd0, vecs[i].e_req_valid});
      chk($sformatf("v%0d_out_valid", i), {63'd0, io_out_valid},     {63'd0, vecs[i].e_out_valid});
      chk($sformatf("v%0d_count", i),     {61'd0, io_count},         {61'd0, vecs[i].e_count});
      if (vecs[i].e_req_valid)
        chk($sformatf("v%0d_req_addr", i), {32'd0, io_mem_req_bits_address}, {32'd0, vecs[i].e_req_addr});
      if (vecs[i].e_out_valid) begin
        chk($sformatf("v%0d_out_addr", i), {32'd0, io_out_bits_address}, {32'd0, vecs[i].e_out_addr});
        chk($sformatf("v%0d_out_data", i), {32'd0, io_out_bits_data},    {32'd0, vecs[i].e_out_data});
      end
      step();
    end
    idle_inputs();

    // Fill: memory stalled, first entry loads, next four fill the FIFO.
    for (int k = 0; k < 5; k++) begin
      io_in_valid        = 1'b1;
      io_in_bits_address = 32'h100 + 32'(k) * 32'h10;
      step();
    end
    #1;
    chk("fill_count",     {61'd0, io_count},                 64'd4);
    chk("fill_in_ready",  {63'd0, io_in_ready},              64'd0);
    chk("fill_req_valid", {63'd0, io_mem_req_valid},         64'd1);
    chk("fill_req_addr",  {32'd0, io_mem_req_bits_address},  64'h100);
    io_in_bits_address = 32'h150;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("stall_in_ready", {63'd0, io_in_ready}, 64'd0);
      chk("stall_count",    {61'd0, io_count},    64'd4);
    end
    @(negedge clock);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'h100 + 32'(k) * 32'h10);
    send_q.push_back(32'h150);
    run_stream(1'b0, 200);

    // Stream with random stalls.
    for (int k = 0; k < 8; k++) send_q.push_back(32'(k) * 32'd4);
    run_stream(1'b1, 2000);

    // Wrap: twelve transactions, continuous enqueue against dequeue.
    for (int k = 0; k < 12; k++) send_q.push_back(32'hA000 + 32'(k) * 32'd4);
    run_stream(1'b0, 500);
    chk("wrap_count_end", {61'd0, io_count}, 64'd0);

    // Reset while waiting on memory with three entries queued.
    io_mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      io_in_valid        = 1'b1;
      io_in_bits_address = 32'hB000 + 32'(k);
      step();
    end
    idle_inputs();
    #1;
    chk("pre_rst_count",     {61'd0, io_count},         64'd3);
    chk("pre_rst_req_valid", {63'd0, io_mem_req_valid}, 64'd0);
    chk("pre_rst_out_valid", {63'd0, io_out_valid},     64'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_count",    {61'd0, io_count},                 64'd0);
    chk("async_rst_in_ready", {63'd0, io_in_ready},              64'd1);
    chk("async_rst_req_addr", {32'd0, io_mem_req_bits_address},  64'd0);
    chk("async_rst_out_data", {32'd0, io_out_bits_data},         64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    io_mem_resp_valid     = 1'b1;
    io_mem_resp_bits_data = 32'h5555AAAA;
    step();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_out_valid", {63'd0, io_out_valid},     64'd0);
      chk("post_rst_req_valid", {63'd0, io_mem_req_valid}, 64'd0);
      chk("post_rst_count",     {61'd0, io_count},         64'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
